dlfloat16_round_out: RTL

Output rounding and normalisation stage placed directly after the DLFloat16 divider. Accepts the divider's 20-bit extended result {sign, 6-bit exponent, 13-bit mantissa} and its 5-bit exception flags. Produces a packed 16-bit DLFloat16 word (1/6/9, bias 31) using round-to-nearest-even, merges the new exception flags, and keeps a sticky flag register. Data moves over valid/ready handshakes on both sides, through a 2-entry skid buffer so that `in_ready` is a registered signal.

---
 rtl/dlfloat16_round_out.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/dlfloat16_round_out.sv
// Rounding/normalisation stage after the DLFloat16 divider: packs the 20-bit extended
// quotient into a 1/6/9 word with RNE, merges exception flags, and buffers through a 2-entry skid.
module dlfloat16_round_out (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [19:0] in_data,
   input  logic [4:0]  in_flags,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_data,
   output logic [4:0]  out_flags,
   input  logic        flags_clr,
   output logic [4:0]  sticky_flags
);

   // Flag bit positions: {invalid, inexact, overflow, underflow, div_by_zero}
   localparam logic [4:0] FLAG_INEXACT   = 5'b01000;
   localparam logic [4:0] FLAG_OVERFLOW  = 5'b00100;
   localparam logic [4:0] FLAG_UNDERFLOW = 5'b00010;

   logic        sign;
   logic [5:0]  exp_in;
   logic [12:0] mant_in;
   logic [12:0] mant_n;
   logic [5:0]  exp_n;
   logic        round_up;
   logic [9:0]  frac_sum;
   logic [6:0]  exp_fin;
   logic [15:0] rnd_data;
   logic [4:0]  rnd_flags;
   logic [4:0]  new_flags;

   always_comb begin
      sign     = in_data[19];
      exp_in   = in_data[18:13];
      mant_in  = in_data[12:0];
      mant_n   = mant_in;
      exp_n    = exp_in;
      // Single-step normalisation; the sticky bit stays sticky after the shift.
      if (!mant_in[12]) begin
         mant_n = {mant_in[11:0], mant_in[0]};
         exp_n  = exp_in - 6'd1;
      end
      round_up  = mant_n[2] & (mant_n[1] | mant_n[0] | mant_n[3]);
      frac_sum  = {1'b0, mant_n[11:3]} + {9'b0, round_up};
      exp_fin   = {1'b0, exp_n} + {6'b0, frac_sum[9]};
      rnd_data  = 16'h0000;
      rnd_flags = 5'b00000;
      if (exp_in == 6'h3F) begin
         rnd_data = {sign, 6'h3F, (mant_in[11:3] != 9'h000) ? 9'h1FF : 9'h000};
      end else if (exp_in == 6'h00) begin
         rnd_data = {sign, 15'h0000};
         if (mant_in != 13'h0000) begin
            rnd_flags = FLAG_UNDERFLOW | FLAG_INEXACT;
         end
      end else if (exp_n == 6'h00) begin
         rnd_data  = {sign, 15'h0000};
         rnd_flags = FLAG_UNDERFLOW | FLAG_INEXACT;
      end else if (exp_fin >= 7'd63) begin
         rnd_data  = {sign, 6'h3E, 9'h1FF};
         rnd_flags = FLAG_OVERFLOW | FLAG_INEXACT;
      end else begin
         rnd_data = {sign, exp_fin[5:0], frac_sum[8:0]};
         if (mant_n[2:0] != 3'b000) begin
            rnd_flags = FLAG_INEXACT;
         end
      end
      new_flags = in_flags | rnd_flags;
   end

   logic        out_valid_q, out_valid_d;
   logic [15:0] out_data_q, out_data_d;
   logic [4:0]  out_flags_q, out_flags_d;
   logic        skid_valid_q, skid_valid_d;
   logic [15:0] skid_data_q, skid_data_d;
   logic [4:0]  skid_flags_q, skid_flags_d;
   logic        in_ready_q, in_ready_d;
   logic [4:0]  sticky_q, sticky_d;
   logic        accept;
   logic        drain;

   assign accept = in_valid & in_ready_q;
   assign drain  = out_valid_q & out_ready;

   always_comb begin
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      out_flags_d  = out_flags_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      skid_flags_d = skid_flags_q;
      // in_ready is low whenever the skid entry holds data, so accept and skid refill never overlap.
      if (skid_valid_q) begin
         if (drain) begin
            out_data_d   = skid_data_q;
            out_flags_d  = skid_flags_q;
            skid_valid_d = 1'b0;
         end
      end else if (accept) begin
         if (!out_valid_q || out_ready) begin
            out_valid_d = 1'b1;
            out_data_d  = rnd_data;
            out_flags_d = new_flags;
         end else begin
            skid_valid_d = 1'b1;
            skid_data_d  = rnd_data;
            skid_flags_d = new_flags;
         end
      end else if (drain) begin
         out_valid_d = 1'b0;
      end
      in_ready_d = ~skid_valid_d;

      sticky_d = sticky_q;
      if (flags_clr) begin
         sticky_d = accept ? new_flags : 5'b00000;
      end else if (accept) begin
         sticky_d = sticky_q | new_flags;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q  <= 1'b0;
         out_data_q   <= 16'h0000;
         out_flags_q  <= 5'b00000;
         skid_valid_q <= 1'b0;
         skid_data_q  <= 16'h0000;
         skid_flags_q <= 5'b00000;
         in_ready_q   <= 1'b1;
         sticky_q     <= 5'b00000;
      end else begin
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         out_flags_q  <= out_flags_d;
         skid_valid_q <= skid_valid_d;
         skid_data_q  <= skid_data_d;
         skid_flags_q <= skid_flags_d;
         in_ready_q   <= in_ready_d;
         sticky_q     <= sticky_d;
      end
   end

   assign in_ready     = in_ready_q;
   assign out_valid    = out_valid_q;
   assign out_data     = out_data_q;
   assign out_flags    = out_flags_q;
   assign sticky_flags = sticky_q;

endmodule
